// File: rtl/bp_axi_dram_window.sv
// bp_axi_dram_window: AW/AR address path between the BP cache DMA master and
// the PS m00 AXI4 port. Each address channel goes through a 2-entry registered
// skid buffer. Addresses are rebased into the PS window on the way in:
//   out = ((in - dram_base_p) & window_mask_i) + dram_offset_i.
// In-flight bursts are capped per direction. The first out-of-window access is
// latched for host readback. W/R/B payloads bypass this block; only their
// handshakes are observed here, and only to retire outstanding bursts.
// Optional build macro: BP_AXI_DRAM_WINDOW_PERF_EN adds burst and stall
// performance counters.

// Underflow monitor for an outstanding-burst counter.
module bp_axi_dram_window_chk #(
  parameter int cnt_width_p = 3
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic                   inc_i,
  input logic                   dec_i,
  input logic [cnt_width_p-1:0] cnt_i
);

  // A completion while nothing is in flight means the PS side broke protocol.
  underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(dec_i && !inc_i && (cnt_i == '0)));

endmodule

// One address channel: 2-entry skid buffer plus outstanding-burst counter.
module bp_axi_dram_window_chan #(
  parameter int data_width_p      = 46,
  parameter int max_outstanding_p = 4,
  localparam int cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [data_width_p-1:0] s_data_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [data_width_p-1:0] m_data_o,
  input  logic                    done_i,
  output logic                    accept_o,
  output logic [cnt_width_lp-1:0] outstanding_o
);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  skid_state_e             state_q;
  logic [data_width_p-1:0] ent0_q;
  logic [data_width_p-1:0] ent1_q;
  logic                    valid_q;
  logic                    ready_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic [cnt_width_lp-1:0] cnt_d;
  logic                    full_d;
  logic                    push_s;
  logic                    pop_s;

  assign push_s        = s_valid_i & ready_q;
  assign pop_s         = valid_q & m_ready_i;
  assign s_ready_o     = ready_q;
  assign m_valid_o     = valid_q;
  assign m_data_o      = ent0_q;
  assign accept_o      = push_s;
  assign outstanding_o = cnt_q;

  // Predict whether the skid will hold two entries after this edge.
  always_comb begin
    full_d = 1'b0;
    case (state_q)
      SKID_ONE: full_d = push_s & ~pop_s;
      SKID_TWO: full_d = ~pop_s;
      default:  full_d = 1'b0;
    endcase
  end

  // Next outstanding count; same-cycle accept and completion cancel, and a
  // stray completion at zero is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (push_s && !done_i) begin
      cnt_d = cnt_q + cnt_width_lp'(1);
    end else if (!push_s && done_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_width_lp'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Skid FSM: head entry drives the downstream payload, order is FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SKID_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push_s) begin
            ent0_q  <= s_data_i;
            valid_q <= 1'b1;
            state_q <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (push_s && pop_s) begin
            ent0_q <= s_data_i;
          end else if (push_s) begin
            ent1_q  <= s_data_i;
            state_q <= SKID_TWO;
          end else if (pop_s) begin
            valid_q <= 1'b0;
            state_q <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (pop_s) begin
            ent0_q  <= ent1_q;
            state_q <= SKID_ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= SKID_EMPTY;
        end
      endcase
    end
  end

  // Registered upstream ready and counter: ready depends only on local
  // state, never on m_ready_i in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ~full_d & (cnt_d < cnt_width_lp'(max_outstanding_p));
    end
  end

  bp_axi_dram_window_chk #(.cnt_width_p(cnt_width_lp)) chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (push_s),
    .dec_i   (done_i),
    .cnt_i   (cnt_q)
  );

endmodule

module bp_axi_dram_window #(
  parameter int                         in_addr_width_p   = 33,
  parameter int                         out_addr_width_p  = 32,
  parameter int                         id_width_p        = 6,
  parameter logic [in_addr_width_p-1:0] dram_base_p       = 33'h0_8000_0000,
  parameter int                         max_outstanding_p = 4,
  localparam int                        cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [out_addr_width_p-1:0] dram_offset_i,
  input  logic [out_addr_width_p-1:0] window_mask_i,
  input  logic [in_addr_width_p-1:0]  s_awaddr_i,
  input  logic [id_width_p-1:0]       s_awid_i,
  input  logic [7:0]                  s_awlen_i,
  input  logic                        s_awvalid_i,
  output logic                        s_awready_o,
  output logic [out_addr_width_p-1:0] m_awaddr_o,
  output logic [id_width_p-1:0]       m_awid_o,
  output logic [7:0]                  m_awlen_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  input  logic [in_addr_width_p-1:0]  s_araddr_i,
  input  logic [id_width_p-1:0]       s_arid_i,
  input  logic [7:0]                  s_arlen_i,
  input  logic                        s_arvalid_i,
  output logic                        s_arready_o,
  output logic [out_addr_width_p-1:0] m_araddr_o,
  output logic [id_width_p-1:0]       m_arid_o,
  output logic [7:0]                  m_arlen_o,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  input  logic                        m_bvalid_i,
  input  logic                        m_bready_i,
  input  logic                        m_rvalid_i,
  input  logic                        m_rready_i,
  input  logic                        m_rlast_i,
  output logic                        err_o,
  output logic [in_addr_width_p-1:0]  err_addr_o,
`ifdef BP_AXI_DRAM_WINDOW_PERF_EN
  output logic [31:0]                 wr_bursts_o,
  output logic [31:0]                 rd_bursts_o,
  output logic [31:0]                 stall_cycles_o,
`endif
  output logic [cnt_width_lp-1:0]     wr_outstanding_o,
  output logic [cnt_width_lp-1:0]     rd_outstanding_o
);

  localparam int pay_width_lp = out_addr_width_p + id_width_p + 8;

  // Rebase into the PS window: subtract at full input width, mask, add, truncate.
  function automatic logic [out_addr_width_p-1:0] rebase_addr(
    input logic [in_addr_width_p-1:0]  addr,
    input logic [out_addr_width_p-1:0] mask,
    input logic [out_addr_width_p-1:0] offset
  );
    logic [in_addr_width_p-1:0] diff;
    diff = addr - dram_base_p;
    rebase_addr = (diff[out_addr_width_p-1:0] & mask) + offset;
  endfunction

  // Below the DRAM base, or any offset bit outside the window, is a miss.
  function automatic logic out_of_window(
    input logic [in_addr_width_p-1:0]  addr,
    input logic [out_addr_width_p-1:0] mask
  );
    logic [in_addr_width_p-1:0] diff;
    logic [in_addr_width_p-1:0] mask_ext;
    diff     = addr - dram_base_p;
    mask_ext = {{(in_addr_width_p - out_addr_width_p){1'b0}}, mask};
    out_of_window = (addr < dram_base_p) | ((diff & ~mask_ext) != '0);
  endfunction

  logic [pay_width_lp-1:0]    aw_in_s;
  logic [pay_width_lp-1:0]    aw_out_s;
  logic [pay_width_lp-1:0]    ar_in_s;
  logic [pay_width_lp-1:0]    ar_out_s;
  logic                       aw_acc_s;
  logic                       ar_acc_s;
  logic                       aw_bad_s;
  logic                       ar_bad_s;
  logic                       err_q;
  logic [in_addr_width_p-1:0] err_addr_q;

  assign aw_in_s  = {rebase_addr(s_awaddr_i, window_mask_i, dram_offset_i), s_awid_i, s_awlen_i};
  assign ar_in_s  = {rebase_addr(s_araddr_i, window_mask_i, dram_offset_i), s_arid_i, s_arlen_i};
  assign aw_bad_s = out_of_window(s_awaddr_i, window_mask_i);
  assign ar_bad_s = out_of_window(s_araddr_i, window_mask_i);

  bp_axi_dram_window_chan #(
    .data_width_p      (pay_width_lp),
    .max_outstanding_p (max_outstanding_p)
  ) aw_chan (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .s_valid_i     (s_awvalid_i),
    .s_ready_o     (s_awready_o),
    .s_data_i      (aw_in_s),
    .m_valid_o     (m_awvalid_o),
    .m_ready_i     (m_awready_i),
    .m_data_o      (aw_out_s),
    .done_i        (m_bvalid_i & m_bready_i),
    .accept_o      (aw_acc_s),
    .outstanding_o (wr_outstanding_o)
  );

  bp_axi_dram_window_chan #(
    .data_width_p      (pay_width_lp),
    .max_outstanding_p (max_outstanding_p)
  ) ar_chan (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .s_valid_i     (s_arvalid_i),
    .s_ready_o     (s_arready_o),
    .s_data_i      (ar_in_s),
    .m_valid_o     (m_arvalid_o),
    .m_ready_i     (m_arready_i),
    .m_data_o      (ar_out_s),
    .done_i        (m_rvalid_i & m_rready_i & m_rlast_i),
    .accept_o      (ar_acc_s),
    .outstanding_o (rd_outstanding_o)
  );

  assign m_awaddr_o = aw_out_s[pay_width_lp-1 -: out_addr_width_p];
  assign m_awid_o   = aw_out_s[8 +: id_width_p];
  assign m_awlen_o  = aw_out_s[7:0];
  assign m_araddr_o = ar_out_s[pay_width_lp-1 -: out_addr_width_p];
  assign m_arid_o   = ar_out_s[8 +: id_width_p];
  assign m_arlen_o  = ar_out_s[7:0];
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

  // Sticky capture of the first out-of-window accept; AW wins a same-cycle tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (!err_q && aw_acc_s && aw_bad_s) begin
      err_q      <= 1'b1;
      err_addr_q <= s_awaddr_i;
    end else if (!err_q && ar_acc_s && ar_bad_s) begin
      err_q      <= 1'b1;
      err_addr_q <= s_araddr_i;
    end else begin
      err_q      <= err_q;
      err_addr_q <= err_addr_q;
    end
  end

`ifdef BP_AXI_DRAM_WINDOW_PERF_EN
  logic [31:0] wr_bursts_q;
  logic [31:0] rd_bursts_q;
  logic [31:0] stall_cycles_q;

  assign wr_bursts_o    = wr_bursts_q;
  assign rd_bursts_o    = rd_bursts_q;
  assign stall_cycles_o = stall_cycles_q;

  // Count downstream address handshakes and cycles where the master is held off.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_bursts_q    <= 32'd0;
      rd_bursts_q    <= 32'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      if (m_awvalid_o && m_awready_i) begin
        wr_bursts_q <= wr_bursts_q + 32'd1;
      end else begin
        wr_bursts_q <= wr_bursts_q;
      end
      if (m_arvalid_o && m_arready_i) begin
        rd_bursts_q <= rd_bursts_q + 32'd1;
      end else begin
        rd_bursts_q <= rd_bursts_q;
      end
      if ((s_awvalid_i && !s_awready_o) || (s_arvalid_i && !s_arready_o)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
    end
  end
`endif

endmodule
